// File: rtl/conv_peak_tdoa_pkg.sv
// Shared definitions for the convolution peak / time-difference stage:
// measurement FSM encoding and the dead-time counter width helper.
package conv_peak_tdoa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPORT = 2'd2
    } tdoa_state_e;

    // Bits needed to hold 0..dead; never narrower than one bit so DEAD=0 still builds.
    function automatic int dead_cnt_w(input int dead);
        int w;
        w = $clog2(dead + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/conv_peak_ch.sv
// One correlation channel: 3-sample window, fill count, thresholded local-maximum
// detection with a dead time, and the registered PEAK_VAL / peak_en outputs.
module conv_peak_ch
    import conv_peak_tdoa_pkg::*;
#(
    parameter int DW     = 16,
    parameter int DEAD   = 8,
    parameter int SIGNED = 1
)(
    input  logic          clks,
    input  logic          rst,
    input  logic          data_en,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] thr,
    output logic [DW-1:0] peak_val,
    output logic          peak_en
);

    localparam int             DCW       = dead_cnt_w(DEAD);
    localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD);

    logic [DW-1:0]  x2_q, x2_d, x1_q, x1_d, x0_q, x0_d;
    logic [1:0]     fill_q, fill_d;
    logic [DCW-1:0] dead_q, dead_d;
    logic [DW-1:0]  peak_val_q, peak_val_d;
    logic           peak_en_q, peak_en_d;
    logic           peak_hit_s;

    // a > b in the configured number representation
    function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic r;
        if (SIGNED != 0) begin
            r = ($signed(a) > $signed(b));
        end else begin
            r = (a > b);
        end
        return r;
    endfunction

    // Shift the window on each strobe and judge the window it will hold after the
    // shift (x2=x1_q, x1=x0_q, x0=din), so peak_en rises one cycle after the strobe.
    always_comb begin
        x2_d       = x2_q;
        x1_d       = x1_q;
        x0_d       = x0_q;
        fill_d     = fill_q;
        dead_d     = dead_q;
        peak_val_d = peak_val_q;
        peak_en_d  = 1'b0;
        peak_hit_s = 1'b0;
        if (data_en) begin
            x2_d = x1_q;
            x1_d = x0_q;
            x0_d = din;
            if (fill_q != 2'd3) begin
                fill_d = fill_q + 2'd1;
            end else begin
                fill_d = fill_q;
            end
            // rising into x1, not rising out of it (flat top reports once), above threshold
            peak_hit_s = (fill_q >= 2'd2) && gt(x0_q, x1_q) && !gt(din, x0_q) &&
                         gt(x0_q, thr) && (dead_q == {DCW{1'b0}});
            if (peak_hit_s) begin
                peak_en_d  = 1'b1;
                peak_val_d = x0_q;
                dead_d     = DEAD_LOAD;
            end else if (dead_q != {DCW{1'b0}}) begin
                dead_d = dead_q - {{(DCW-1){1'b0}}, 1'b1};
            end else begin
                dead_d = dead_q;
            end
        end else begin
            peak_en_d = 1'b0;
        end
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clks) begin
        if (rst) begin
            x2_q       <= {DW{1'b0}};
            x1_q       <= {DW{1'b0}};
            x0_q       <= {DW{1'b0}};
            fill_q     <= 2'd0;
            dead_q     <= {DCW{1'b0}};
            peak_val_q <= {DW{1'b0}};
            peak_en_q  <= 1'b0;
        end else begin
            x2_q       <= x2_d;
            x1_q       <= x1_d;
            x0_q       <= x0_d;
            fill_q     <= fill_d;
            dead_q     <= dead_d;
            peak_val_q <= peak_val_d;
            peak_en_q  <= peak_en_d;
        end
    end

    assign peak_val = peak_val_q;
    assign peak_en  = peak_en_q;

endmodule

// File: rtl/conv_peak_tdoa.sv
// Multi-channel convolution peak detector with time-difference measurement of
// each channel's first peak relative to the channel-0 reference peak.
module conv_peak_tdoa
    import conv_peak_tdoa_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DW     = 16,
    parameter int TW     = 16,
    parameter int DEAD   = 8,
    parameter int SIGNED = 1
)(
    input  logic                  clks,
    input  logic                  rst,
    input  logic                  data_en,
    input  logic [NCH*DW-1:0]     DATA_IN,
    input  logic [DW-1:0]         FIX_POROG,
    input  logic [TW-1:0]         T_MAX,
    output logic [NCH*DW-1:0]     PEAK_VAL,
    output logic [NCH-1:0]        peak_en,
    output logic [(NCH-1)*TW-1:0] SUB_T,
    output logic [NCH-2:0]        sub_t_vld,
    output logic                  sub_t_en
);

    localparam logic [TW-1:0] TW_ONES = {TW{1'b1}};

    tdoa_state_e              state_q, state_d;
    logic [TW-1:0]            scnt_q, scnt_d;
    logic [(NCH-1)*TW-1:0]    sub_t_q, sub_t_d;
    logic [NCH-2:0]           vld_q, vld_d;
    logic                     sub_t_en_q, sub_t_en_d;
    logic [TW-1:0]            tmax_eff_s, scnt_inc_s;
    logic                     all_cap_s;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        conv_peak_ch #(
            .DW     (DW),
            .DEAD   (DEAD),
            .SIGNED (SIGNED)
        ) u_ch (
            .clks     (clks),
            .rst      (rst),
            .data_en  (data_en),
            .din      (DATA_IN[k*DW +: DW]),
            .thr      (FIX_POROG),
            .peak_val (PEAK_VAL[k*DW +: DW]),
            .peak_en  (peak_en[k])
        );
    end

    // Measurement FSM: arm on a reference peak, capture first peaks, report once.
    // The valid flags double as the per-channel "already captured" marks.
    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        sub_t_d    = sub_t_q;
        vld_d      = vld_q;
        all_cap_s  = 1'b0;
        tmax_eff_s = (T_MAX == {TW{1'b0}}) ? TW_ONES : T_MAX;
        scnt_inc_s = (scnt_q == TW_ONES) ? scnt_q : (scnt_q + {{(TW-1){1'b0}}, 1'b1});
        case (state_q)
            ST_IDLE: begin
                if (peak_en[0]) begin
                    scnt_d = {TW{1'b0}};
                    for (int k = 1; k < NCH; k++) begin
                        if (peak_en[k]) begin
                            sub_t_d[(k-1)*TW +: TW] = {TW{1'b0}};
                            vld_d[k-1]              = 1'b1;
                        end else begin
                            sub_t_d[(k-1)*TW +: TW] = TW_ONES;
                            vld_d[k-1]              = 1'b0;
                        end
                    end
                    all_cap_s = &vld_d;
                    if (all_cap_s) begin
                        state_d = ST_REPORT;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (data_en) begin
                    scnt_d = scnt_inc_s;
                end else begin
                    scnt_d = scnt_q;
                end
                for (int k = 1; k < NCH; k++) begin
                    if (peak_en[k] && !vld_q[k-1]) begin
                        sub_t_d[(k-1)*TW +: TW] = scnt_q;
                        vld_d[k-1]              = 1'b1;
                    end else begin
                        sub_t_d[(k-1)*TW +: TW] = sub_t_q[(k-1)*TW +: TW];
                        vld_d[k-1]              = vld_q[k-1];
                    end
                end
                all_cap_s = &vld_d;
                if (all_cap_s || (data_en && (scnt_inc_s >= tmax_eff_s))) begin
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_REPORT) begin
            sub_t_en_d = 1'b1;
        end else begin
            sub_t_en_d = 1'b0;
        end
    end

    // FSM, sample counter and capture registers with synchronous reset
    always_ff @(posedge clks) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            scnt_q     <= {TW{1'b0}};
            sub_t_q    <= {((NCH-1)*TW){1'b0}};
            vld_q      <= {(NCH-1){1'b0}};
            sub_t_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            sub_t_q    <= sub_t_d;
            vld_q      <= vld_d;
            sub_t_en_q <= sub_t_en_d;
        end
    end

    assign SUB_T     = sub_t_q;
    assign sub_t_vld = vld_q;
    assign sub_t_en  = sub_t_en_q;

endmodule
